// File: rtl/pq_pkg.sv
// Shared key-value payload and priority-queue geometry for pq_if devices and their initiators.
package pq_pkg;

    localparam int unsigned KEY_WIDTH   = 8;
    localparam int unsigned VAL_WIDTH   = 8;
    localparam int unsigned PQ_CAPACITY = 8;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;

endpackage

// File: rtl/pq_batch_sorter_if.sv
// Input stream, sorted output stream and pq_if command/status bundle of pq_batch_sorter.
interface pq_batch_sorter_if;
    import pq_pkg::*;

    logic in_valid;
    logic in_ready;
    kv_t  in_kv;
    logic in_last;
    logic out_valid;
    logic out_ready;
    kv_t  out_kv;
    logic out_last;
    logic overflow;
    logic pq_enq;
    logic pq_deq;
    kv_t  pq_kvi;
    kv_t  pq_kvo;
    logic pq_full;
    logic pq_empty;
    logic pq_busy;

    // master: the sorter itself; slave: producers, consumer and the PQ device
    modport master (
        input  in_valid, in_kv, in_last, out_ready, pq_kvo, pq_full, pq_empty, pq_busy,
        output in_ready, out_valid, out_kv, out_last, overflow, pq_enq, pq_deq, pq_kvi
    );

    modport slave (
        output in_valid, in_kv, in_last, out_ready, pq_kvo, pq_full, pq_empty, pq_busy,
        input  in_ready, out_valid, out_kv, out_last, overflow, pq_enq, pq_deq, pq_kvi
    );

endinterface

// File: rtl/pq_batch_sorter.sv
// Fills an attached priority queue with one input batch, then drains it in ascending key order.
module pq_batch_sorter
    import pq_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    pq_batch_sorter_if.master bus
);

    localparam int unsigned CNT_W = $clog2(PQ_CAPACITY + 1);
    localparam int unsigned GRD_W = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PQ_CAPACITY);

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        ENQ_WAIT = 2'd1,
        DRAIN    = 2'd2,
        DEQ_WAIT = 2'd3
    } state_t;

    state_t           state,     state_d;
    logic [CNT_W-1:0] cnt,       cnt_d;
    logic [GRD_W-1:0] gcnt,      gcnt_d;
    logic             last,      last_d;
    logic             overflow,  overflow_d;
    logic             out_valid, out_valid_d;
    logic             out_last,  out_last_d;
    kv_t              out_kv,    out_kv_d;
    logic             pq_enq,    pq_enq_d;
    logic             pq_deq,    pq_deq_d;
    kv_t              pq_kvi,    pq_kvi_d;
    logic             in_ready_c;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            cnt       <= '0;
            gcnt      <= '0;
            last      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_kv    <= '0;
            pq_enq    <= 1'b0;
            pq_deq    <= 1'b0;
            pq_kvi    <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            gcnt      <= gcnt_d;
            last      <= last_d;
            overflow  <= overflow_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            out_kv    <= out_kv_d;
            pq_enq    <= pq_enq_d;
            pq_deq    <= pq_deq_d;
            pq_kvi    <= pq_kvi_d;
        end
    end

    // Next state; commands are registered so the guard window starts with the command cycle
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        gcnt_d      = gcnt;
        last_d      = last;
        overflow_d  = overflow;
        out_valid_d = out_valid;
        out_last_d  = out_last;
        out_kv_d    = out_kv;
        pq_enq_d    = 1'b0;
        pq_deq_d    = 1'b0;
        pq_kvi_d    = pq_kvi;
        in_ready_c  = 1'b0;

        if (out_valid && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state)
            FILL: begin
                in_ready_c = !bus.pq_busy && !bus.pq_full;
                if (bus.in_valid && in_ready_c) begin
                    pq_enq_d = 1'b1;
                    pq_kvi_d = bus.in_kv;
                    if (cnt != CNT_MAX) begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                    last_d  = bus.in_last;
                    gcnt_d  = GRD_W'(GUARD_CYCLES);
                    state_d = ENQ_WAIT;
                end
            end
            ENQ_WAIT: begin
                if (gcnt != '0) begin
                    gcnt_d = gcnt - GRD_W'(1);
                end else if (!bus.pq_busy) begin
                    if (last) begin
                        state_d = DRAIN;
                    end else if (bus.pq_full) begin
                        overflow_d = 1'b1;
                        state_d    = DRAIN;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            DRAIN: begin
                // An empty PQ with cnt != 0 is a device protocol error: hold here without dequeuing
                if (!bus.pq_busy && !bus.pq_empty && (!out_valid || bus.out_ready)) begin
                    out_kv_d    = bus.pq_kvo;
                    out_valid_d = 1'b1;
                    out_last_d  = (cnt == CNT_W'(1));
                    pq_deq_d    = 1'b1;
                    if (cnt != '0) begin
                        cnt_d = cnt - CNT_W'(1);
                    end
                    gcnt_d  = GRD_W'(GUARD_CYCLES);
                    state_d = DEQ_WAIT;
                end
            end
            DEQ_WAIT: begin
                if (gcnt != '0) begin
                    gcnt_d = gcnt - GRD_W'(1);
                end else if (!bus.pq_busy) begin
                    state_d = (cnt != '0) ? DRAIN : FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_c && !rst;
    assign bus.out_valid = out_valid;
    assign bus.out_kv    = out_kv;
    assign bus.out_last  = out_last;
    assign bus.overflow  = overflow;
    assign bus.pq_enq    = pq_enq;
    assign bus.pq_deq    = pq_deq;
    assign bus.pq_kvi    = pq_kvi;

endmodule

// File: tb/tb_pq_batch_sorter.sv
// Bench for pq_batch_sorter: behavioural PQ device, scoreboard on the sorted stream, command protocol monitor.
module tb_pq_batch_sorter;
    import pq_pkg::*;

    typedef struct packed {
        kv_t  kv;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pq_batch_sorter_if bus();

    pq_batch_sorter #(.GUARD_CYCLES(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_out  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Behavioural PQ device: sorted array, busy for busy_len cycles after each command
    kv_t         mem [PQ_CAPACITY];
    int unsigned m_cnt    = 0;
    int          busy_cnt = 0;
    int          busy_len = 2;

    assign bus.pq_kvo   = (m_cnt != 0) ? mem[0] : '0;
    assign bus.pq_full  = (m_cnt == PQ_CAPACITY);
    assign bus.pq_empty = (m_cnt == 0);
    assign bus.pq_busy  = (busy_cnt != 0);

    always @(posedge clk) begin : pq_model
        kv_t tmp [PQ_CAPACITY];
        int  c;
        int  pos;
        tmp = mem;
        c   = int'(m_cnt);
        if (rst) begin
            c = 0;
            busy_cnt <= 0;
        end else begin
            if (bus.pq_enq && !bus.pq_deq) begin
                if (c < int'(PQ_CAPACITY)) begin
                    pos = c;
                    for (int i = 0; i < c; i++) begin
                        if (bus.pq_kvi.key < tmp[i].key) begin
                            pos = i;
                            break;
                        end
                    end
                    for (int i = c; i > pos; i--) tmp[i] = tmp[i-1];
                    tmp[pos] = bus.pq_kvi;
                    c++;
                end else begin
                    fail_now("enq_when_full");
                end
            end
            if (bus.pq_deq && !bus.pq_enq) begin
                if (c != 0) begin
                    for (int i = 0; i < int'(PQ_CAPACITY) - 1; i++) tmp[i] = tmp[i+1];
                    c--;
                end else begin
                    fail_now("deq_when_empty");
                end
            end
            if (bus.pq_enq || bus.pq_deq) busy_cnt <= busy_len;
            else if (busy_cnt != 0)        busy_cnt <= busy_cnt - 1;
        end
        mem   <= tmp;
        m_cnt <= c;
    end

    // out_ready driver: always ready, or the repeating 1-0-0-1 backpressure pattern
    int         rdy_mode = 0;
    logic [3:0] rdy_pat  = 4'b1001;
    initial begin
        int ph;
        ph = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                bus.out_ready = 1'b1;
            end else begin
                bus.out_ready = rdy_pat[ph];
                ph = (ph + 1) % 4;
            end
        end
    end

    // Monitor: scoreboard pop, stall stability and command legality
    logic hold      = 1'b0;
    kv_t  hold_kv   = '0;
    logic hold_last = 1'b0;
    logic prev_cmd  = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold     = 1'b0;
            prev_cmd = 1'b0;
        end else begin
            if (hold)
                chk("stall_stable", 32'({bus.out_valid, bus.out_kv, bus.out_last}),
                    32'({1'b1, hold_kv, hold_last}));
            if (bus.pq_enq || bus.pq_deq)
                chk("cmd_legal", 32'({bus.pq_enq && bus.pq_deq, bus.pq_busy, prev_cmd, bus.pq_deq && hold}),
                    32'(0));
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_out: got key 0x%0h last %0b, none expected",
                             bus.out_kv.key, bus.out_last);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pair", 32'({bus.out_kv, bus.out_last}), 32'({e.kv, e.last}));
                end
            end
            hold      = bus.out_valid && !bus.out_ready;
            hold_kv   = bus.out_kv;
            hold_last = bus.out_last;
            prev_cmd  = bus.pq_enq || bus.pq_deq;
        end
    end

    function automatic kv_t mk(input logic [KEY_WIDTH-1:0] key);
        kv_t kv;
        kv.key = key;
        kv.val = VAL_WIDTH'(key + 8'd16);
        return kv;
    endfunction

    task automatic expect_out(input logic [KEY_WIDTH-1:0] key, input logic last);
        exp_t e;
        e.kv   = mk(key);
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Called at posedge+#1; returns at posedge+#1 after the handshake
    task automatic send(input logic [KEY_WIDTH-1:0] key, input logic last);
        bit got;
        got = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_kv    = mk(key);
        bus.in_last  = last;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!got) fail_now("send_timeout");
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0 && !bus.out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            fail_now(name);
            exp_q.delete();
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        int target;
        bit got;
        bus.in_valid = 1'b0;
        bus.in_kv    = '0;
        bus.in_last  = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready",  32'(bus.in_ready),  32'(0));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_out_last",  32'(bus.out_last),  32'(0));
        chk("rst_out_kv",    32'(bus.out_kv),    32'(0));
        chk("rst_overflow",  32'(bus.overflow),  32'(0));
        chk("rst_pq_cmd",    32'({bus.pq_enq, bus.pq_deq}), 32'(0));
        chk("rst_pq_kvi",    32'(bus.pq_kvi),    32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1) unordered batch
        busy_len = 2;
        expect_out(8'd1, 1'b0); expect_out(8'd2, 1'b0); expect_out(8'd3, 1'b0);
        expect_out(8'd4, 1'b0); expect_out(8'd5, 1'b1);
        send(8'd5, 1'b0); send(8'd1, 1'b0); send(8'd4, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b1);
        wait_drain("t1_drain");
        chk("t1_cnt_zero", 32'(dut.cnt), 32'(0));
        chk("t1_overflow", 32'(bus.overflow), 32'(0));

        // 2) single-pair batch
        busy_len = 1;
        expect_out(8'd7, 1'b1);
        send(8'd7, 1'b1);
        wait_drain("t2_drain");
        @(negedge clk);
        chk("t2_in_ready", 32'(bus.in_ready), 32'(1));
        @(posedge clk);
        #1;

        // 3) batch 1 under backpressure
        busy_len = 3;
        rdy_mode = 1;
        expect_out(8'd1, 1'b0); expect_out(8'd2, 1'b0); expect_out(8'd3, 1'b0);
        expect_out(8'd4, 1'b0); expect_out(8'd5, 1'b1);
        send(8'd5, 1'b0); send(8'd1, 1'b0); send(8'd4, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b1);
        wait_drain("t3_drain");
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // 4) capacity + 2: first 8 drain as a truncated batch, last 2 as the next one
        busy_len = 2;
        expect_out(8'd10, 1'b0); expect_out(8'd20, 1'b0); expect_out(8'd30, 1'b0);
        expect_out(8'd50, 1'b0); expect_out(8'd60, 1'b0); expect_out(8'd70, 1'b0);
        expect_out(8'd80, 1'b0); expect_out(8'd90, 1'b1);
        expect_out(8'd15, 1'b0); expect_out(8'd40, 1'b1);
        send(8'd50, 1'b0); send(8'd20, 1'b0); send(8'd90, 1'b0); send(8'd10, 1'b0);
        send(8'd70, 1'b0); send(8'd30, 1'b0); send(8'd80, 1'b0); send(8'd60, 1'b0);
        send(8'd40, 1'b0); send(8'd15, 1'b1);
        wait_drain("t4_drain");
        chk("t4_overflow", 32'(bus.overflow), 32'(1));

        // 5) reset after two outputs of a drain
        expect_out(8'd3, 1'b0); expect_out(8'd4, 1'b0);
        target = n_out + 2;
        send(8'd6, 1'b0); send(8'd3, 1'b0); send(8'd5, 1'b0); send(8'd4, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            if (n_out >= target) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("t5_two_outputs");
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_in_ready", 32'(bus.in_ready), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_out_valid", 32'(bus.out_valid), 32'(0));
        chk("t5_pq_cmd",    32'({bus.pq_enq, bus.pq_deq}), 32'(0));
        chk("t5_overflow",  32'(bus.overflow), 32'(0));
        chk("t5_exp_empty", 32'(exp_q.size()), 32'(0));
        @(posedge clk);
        #1;
        expect_out(8'd8, 1'b0); expect_out(8'd9, 1'b1);
        send(8'd9, 1'b0); send(8'd8, 1'b1);
        wait_drain("t5_drain");
        chk("t5_cnt_zero", 32'(dut.cnt), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
